// File: rtl/char_disp_pkg.sv
// Shared constants and scheduler state encoding for the character display write path.
package char_disp_pkg;

  localparam int TXT_COLS = 64;
  localparam int TXT_ROWS = 16;
  localparam int TXT_AW   = $clog2(TXT_COLS * TXT_ROWS);

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2,
    ST_CLEAR = 2'd3
  } sched_state_e;

endpackage

// File: rtl/char_wr_sched_if.sv
// Producer-side handshakes, clear control and RAM write port of the character write scheduler.
interface char_wr_sched_if;
  import char_disp_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [TXT_AW-1:0] a_addr;
  logic [7:0]        a_data;
  logic              a_last;

  logic              b_valid;
  logic              b_ready;
  logic [TXT_AW-1:0] b_addr;
  logic [7:0]        b_data;
  logic              b_last;

  logic              clr_req;
  logic              clr_busy;

  logic [TXT_AW-1:0] ram_Adr;
  logic [7:0]        ram_Data;
  logic              write_Ram;

  modport master (
    output a_valid, a_addr, a_data, a_last, input a_ready,
    output b_valid, b_addr, b_data, b_last, input b_ready,
    output clr_req, input clr_busy,
    input  ram_Adr, ram_Data, write_Ram
  );

  modport slave (
    input  a_valid, a_addr, a_data, a_last, output a_ready,
    input  b_valid, b_addr, b_data, b_last, output b_ready,
    input  clr_req, output clr_busy,
    output ram_Adr, ram_Data, write_Ram
  );

endinterface

// File: rtl/char_clr_seq.sv
// Screen-clear sequencer: pending flag, 10-bit cell counter (one pass, no wrap) and done pulse.
module char_clr_seq
  import char_disp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  input  logic              step,
  output logic              pending,
  output logic              busy,
  output logic              done,
  output logic [TXT_AW-1:0] addr
);

  logic              pending_reg, pending_next;
  logic              busy_reg;
  logic [TXT_AW-1:0] cnt_reg, cnt_next;

  always_comb begin
    done         = step && (cnt_reg == '1);
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    if (done) begin
      cnt_next     = '0;
      pending_next = 1'b0;
    end else begin
      if (step)
        cnt_next = cnt_reg + 1'b1;
      if (clr_req && !busy_reg)
        pending_next = 1'b1;
    end
  end

  // busy stays high through the final write cycle, then drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= 1'b0;
      busy_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      busy_reg    <= pending_next | step;
      cnt_reg     <= cnt_next;
    end
  end

  assign pending = pending_reg;
  assign busy    = busy_reg;
  assign addr    = cnt_reg;

endmodule

// File: rtl/char_wr_sched.sv
// Round-robin write-port scheduler for the char_disp RAM; clear engine built under CHAR_WR_SCHED_CLEAR_EN.
module char_wr_sched
  import char_disp_pkg::*;
#(
  parameter logic [7:0] CLR_CHAR  = BLANK_CHAR,
  parameter int         MAX_BURST = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  char_wr_sched_if.slave  bus
);

  localparam int               BEAT_W    = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic             RR_A      = 1'b0;
  localparam logic             RR_B      = 1'b1;

  sched_state_e      state_reg, state_next;
  logic              rr_reg, rr_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic [TXT_AW-1:0] ram_adr_reg, ram_adr_next;
  logic [7:0]        ram_data_reg, ram_data_next;
  logic              write_reg, write_next;

  logic              a_ready, b_ready, accept_a, accept_b, release_gnt;
  logic              clr_step, clr_pending, clr_busy, clr_done;
  logic [TXT_AW-1:0] clr_addr;

  assign clr_step = (state_reg == ST_CLEAR);

`ifdef CHAR_WR_SCHED_CLEAR_EN
  char_clr_seq u_clr_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_req (bus.clr_req),
    .step    (clr_step),
    .pending (clr_pending),
    .busy    (clr_busy),
    .done    (clr_done),
    .addr    (clr_addr)
  );
`else
  assign clr_pending = 1'b0;
  assign clr_busy    = 1'b0;
  assign clr_done    = 1'b0;
  assign clr_addr    = '0;

  logic unused_clr;
  assign unused_clr = bus.clr_req ^ (^CLR_CHAR) ^ clr_done ^ (^clr_addr) ^ clr_step;
`endif

  always_comb begin
    state_next    = state_reg;
    rr_next       = rr_reg;
    beat_cnt_next = beat_cnt_reg;
    ram_adr_next  = ram_adr_reg;
    ram_data_next = ram_data_reg;
    write_next    = 1'b0;
    release_gnt   = 1'b0;

    a_ready  = (state_reg == ST_GNT_A);
    b_ready  = (state_reg == ST_GNT_B);
    accept_a = a_ready && bus.a_valid;
    accept_b = b_ready && bus.b_valid;

    if (accept_a) begin
      ram_adr_next  = bus.a_addr;
      ram_data_next = bus.a_data;
      write_next    = 1'b1;
      release_gnt   = bus.a_last || (beat_cnt_reg == BEAT_LAST);
    end
    if (accept_b) begin
      ram_adr_next  = bus.b_addr;
      ram_data_next = bus.b_data;
      write_next    = 1'b1;
      release_gnt   = bus.b_last || (beat_cnt_reg == BEAT_LAST);
    end
    if (accept_a || accept_b)
      beat_cnt_next = release_gnt ? '0 : beat_cnt_reg + 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (bus.a_valid && (rr_reg == RR_A || !bus.b_valid))
          state_next = ST_GNT_A;
        else if (bus.b_valid)
          state_next = ST_GNT_B;
        // A pending clear outranks both requesters.
        if (clr_pending)
          state_next = ST_CLEAR;
      end
      ST_GNT_A: begin
        if (release_gnt) begin
          state_next = ST_IDLE;
          rr_next    = RR_B;
        end
      end
      ST_GNT_B: begin
        if (release_gnt) begin
          state_next = ST_IDLE;
          rr_next    = RR_A;
        end
      end
`ifdef CHAR_WR_SCHED_CLEAR_EN
      ST_CLEAR: begin
        ram_adr_next  = clr_addr;
        ram_data_next = CLR_CHAR;
        write_next    = 1'b1;
        if (clr_done)
          state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      rr_reg       <= RR_A;
      beat_cnt_reg <= '0;
      ram_adr_reg  <= '0;
      ram_data_reg <= '0;
      write_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_reg       <= rr_next;
      beat_cnt_reg <= beat_cnt_next;
      ram_adr_reg  <= ram_adr_next;
      ram_data_reg <= ram_data_next;
      write_reg    <= write_next;
    end
  end

  assign bus.a_ready   = a_ready;
  assign bus.b_ready   = b_ready;
  assign bus.clr_busy  = clr_busy;
  assign bus.ram_Adr   = ram_adr_reg;
  assign bus.ram_Data  = ram_data_reg;
  assign bus.write_Ram = write_reg;

endmodule

// File: tb/tb_char_wr_sched.sv
// Directed bench for char_wr_sched: arbitration order, write latency, burst cap and (if built) screen clear.
module tb_char_wr_sched;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  char_wr_sched_if bus();

  char_wr_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [9:0] log_adr[$];
  logic [7:0] log_dat[$];
  logic       log_busy[$];
  int         log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.write_Ram) begin
      log_adr.push_back(bus.ram_Adr);
      log_dat.push_back(bus.ram_Data);
      log_busy.push_back(bus.clr_busy);
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic log_clear();
    log_adr.delete();
    log_dat.delete();
    log_busy.delete();
    log_cyc.delete();
  endtask

  task automatic send(input bit which, input int n, input int burst,
                      input logic [9:0] adr0, input logic [7:0] dat0);
    int waited;
    for (int i = 0; i < n; i++) begin
      if (!which) begin
        bus.a_valid = 1'b1;
        bus.a_addr  = adr0 + 10'(i);
        bus.a_data  = dat0 + 8'(i);
        bus.a_last  = ((i % burst) == burst - 1);
      end else begin
        bus.b_valid = 1'b1;
        bus.b_addr  = adr0 + 10'(i);
        bus.b_data  = dat0 + 8'(i);
        bus.b_last  = ((i % burst) == burst - 1);
      end
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(which ? bus.b_ready : bus.a_ready) && waited < 3000);
      if (waited >= 3000) begin
        if (!which) check("a_ready_timeout", 32'd0, 32'd1);
        else        check("b_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!which) begin
      bus.a_valid = 1'b0;
      bus.a_last  = 1'b0;
    end else begin
      bus.b_valid = 1'b0;
      bus.b_last  = 1'b0;
    end
    $display("send %s: %0d beats from adr 0x%03h done at cycle %0d", which ? "B" : "A", n, adr0, cyc);
  endtask

  task automatic wait_busy_low(input string tag);
    int n = 0;
    while (bus.clr_busy && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.clr_busy}, 32'd0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 bus.clr_req = 1'b1;
    @(posedge clk);
    #1 bus.clr_req = 1'b0;
  endtask

  logic [7:0] ilv_dat[12] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2,
                              8'hA3, 8'hA4, 8'hA5, 8'hB3, 8'hB4, 8'hB5};
  logic [9:0] ilv_adr[12] = '{10'h100, 10'h101, 10'h102, 10'h200, 10'h201, 10'h202,
                              10'h103, 10'h104, 10'h105, 10'h203, 10'h204, 10'h205};

  initial begin
    int bad;
    int a_idx;
    int lim;
    logic [9:0] exp_adr;

    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0; bus.a_last = 1'b0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0; bus.b_last = 1'b0;
    bus.clr_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_write", {31'd0, bus.write_Ram}, 32'd0);
    check("rst_adr",   {22'd0, bus.ram_Adr},   32'd0);
    check("rst_data",  {24'd0, bus.ram_Data},  32'd0);
    check("rst_a_rdy", {31'd0, bus.a_ready},   32'd0);
    check("rst_b_rdy", {31'd0, bus.b_ready},   32'd0);
    check("rst_busy",  {31'd0, bus.clr_busy},  32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Both requesters, 3-beat bursts, rr starts at A
    log_clear();
    fork
      send(1'b0, 6, 3, 10'h100, 8'hA0);
      send(1'b1, 6, 3, 10'h200, 8'hB0);
    join
    repeat (3) @(negedge clk);
    check("ilv_count", log_adr.size(), 12);
    lim = (log_adr.size() < 12) ? log_adr.size() : 12;
    for (int k = 0; k < lim; k++) begin
      check($sformatf("ilv_dat%0d", k), {24'd0, log_dat[k]}, {24'd0, ilv_dat[k]});
      check($sformatf("ilv_adr%0d", k), {22'd0, log_adr[k]}, {22'd0, ilv_adr[k]});
      if (k > 0)
        check($sformatf("ilv_gap%0d", k), log_cyc[k] - log_cyc[k-1], (k % 3 == 0) ? 2 : 1);
    end

    // Single A beat, rr back at A after B's release
    log_clear();
    @(posedge clk);
    #1;
    bus.a_valid = 1'b1; bus.a_addr = 10'h041; bus.a_data = 8'h48; bus.a_last = 1'b1;
    @(negedge clk);
    check("single_rdy_lat", {31'd0, bus.a_ready}, 32'd0);
    @(negedge clk);
    check("single_rdy_gnt", {31'd0, bus.a_ready}, 32'd1);
    check("single_b_rdy",   {31'd0, bus.b_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0; bus.a_last = 1'b0;
    @(negedge clk);
    check("single_write", {31'd0, bus.write_Ram}, 32'd1);
    check("single_adr",   {22'd0, bus.ram_Adr},   32'h041);
    check("single_data",  {24'd0, bus.ram_Data},  32'h48);
    check("single_rdy_off", {31'd0, bus.a_ready}, 32'd0);
    @(negedge clk);
    check("single_strobe_end", {31'd0, bus.write_Ram}, 32'd0);

    // B never asserts last before beat 70: forced release at 64, A (waiting) goes next
    log_clear();
    fork
      send(1'b1, 70, 70, 10'h300, 8'h00);
      send(1'b0, 1, 1, 10'h3FF, 8'hEE);
    join
    repeat (3) @(negedge clk);
    check("cap_count", log_adr.size(), 71);
    a_idx = -1;
    bad = 0;
    for (int k = 0; k < log_adr.size(); k++) begin
      if (log_dat[k] == 8'hEE && a_idx < 0) a_idx = k;
      if (k < 64)       exp_adr = 10'h300 + 10'(k);
      else if (k == 64) exp_adr = 10'h3FF;
      else              exp_adr = 10'h300 + 10'(k - 1);
      if (log_adr[k] != exp_adr) bad++;
    end
    check("cap_a_index", a_idx, 64);
    check("cap_adr_bad", bad, 0);
    if (log_adr.size() >= 66) begin
      check("cap_gap_b_to_a", log_cyc[64] - log_cyc[63], 2);
      check("cap_gap_a_to_b", log_cyc[65] - log_cyc[64], 2);
    end

`ifdef CHAR_WR_SCHED_CLEAR_EN
    // Clear requested during A's 5-beat burst
    log_clear();
    fork
      send(1'b0, 5, 5, 10'h010, 8'h61);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.a_ready && n < 50);
        pulse_clr();
        @(negedge clk);
        check("clr_busy_set", {31'd0, bus.clr_busy}, 32'd1);
        check("clr_no_preempt", {31'd0, bus.a_ready}, 32'd1);
      end
    join
    wait_busy_low("clr_busy_timeout");
    repeat (3) @(negedge clk);
    check("clr_count", log_adr.size(), 1029);
    if (log_adr.size() == 1029) begin
      bad = 0;
      for (int k = 0; k < 5; k++)
        if (log_adr[k] != 10'h010 + 10'(k) || log_dat[k] != 8'h61 + 8'(k)) bad++;
      check("clr_a_beats_bad", bad, 0);
      check("clr_gap_a_to_clr", log_cyc[5] - log_cyc[4], 2);
      bad = 0;
      for (int k = 5; k < 1029; k++) begin
        if (log_adr[k] != 10'(k - 5) || log_dat[k] != 8'h20 || !log_busy[k]) bad++;
        if (k > 5 && log_cyc[k] - log_cyc[k-1] != 1) bad++;
      end
      check("clr_cells_bad", bad, 0);
    end

    // Clear from idle: latency, then reset at step 500, then restart from 0
    pulse_clr();
    @(negedge clk);
    check("clr2_busy", {31'd0, bus.clr_busy}, 32'd1);
    check("clr2_idle_nowr", {31'd0, bus.write_Ram}, 32'd0);
    @(negedge clk);
    check("clr2_enter_nowr", {31'd0, bus.write_Ram}, 32'd0);
    @(negedge clk);
    check("clr2_first_wr", {31'd0, bus.write_Ram}, 32'd1);
    check("clr2_first_adr", {22'd0, bus.ram_Adr}, 32'd0);
    check("clr2_first_dat", {24'd0, bus.ram_Data}, 32'h20);
    bad = 0;
    while (bus.ram_Adr != 10'd500 && bad < 1200) begin
      @(negedge clk);
      bad++;
    end
    check("clr2_reach_500", {22'd0, bus.ram_Adr}, 32'd500);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_write", {31'd0, bus.write_Ram}, 32'd0);
    check("abort_adr",   {22'd0, bus.ram_Adr},   32'd0);
    check("abort_data",  {24'd0, bus.ram_Data},  32'd0);
    check("abort_busy",  {31'd0, bus.clr_busy},  32'd0);
    check("abort_a_rdy", {31'd0, bus.a_ready},   32'd0);
    check("abort_b_rdy", {31'd0, bus.b_ready},   32'd0);
    reset_n = 1'b1;
    log_clear();
    pulse_clr();
    repeat (10) @(negedge clk);
    pulse_clr();
    wait_busy_low("clr3_busy_timeout");
    repeat (20) @(negedge clk);
    check("clr3_count", log_adr.size(), 1024);
    bad = 0;
    for (int k = 0; k < log_adr.size(); k++)
      if (log_adr[k] != 10'(k) || log_dat[k] != 8'h20) bad++;
    check("clr3_cells_bad", bad, 0);
`else
    // Clear engine not built: a request must have no effect
    log_clear();
    pulse_clr();
    @(negedge clk);
    check("noclr_busy", {31'd0, bus.clr_busy}, 32'd0);
    repeat (10) @(negedge clk);
    check("noclr_writes", log_adr.size(), 0);
    check("noclr_busy_late", {31'd0, bus.clr_busy}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
